opc5ls_uart: RTL
================

Name: opc5ls_uart

Overview:
- Memory-mapped 8N1 UART on the OPC5LS CPU data bus (address, dout, rnw from CPU; read data back to CPU din).
- Drives the CPU's active-low int_b interrupt input.
- TX and RX paths each have a FIFO; baud divisor is programmable.
- All register reads are side-effect free. The CPU drives address every cycle with no read strobe, so the RX pop is done by a write to CTRL.

Parameters:
- BASE_ADDR, 16'hFE00, base of 4-word register window; must be 4-aligned.
- TX_DEPTH, 8, TX FIFO entries; power of 2, ≥2.
- RX_DEPTH, 8, RX FIFO entries; power of 2, ≥2.
- DEF_DIV, 16'd433, baud divisor at reset; bit period = DIV+1 clocks.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- address  in  16  CPU address bus.
- wdata  in  16  CPU dout.
- rnw  in  1  CPU read-not-write; low for exactly one cycle per store.
- rdata  out  16  read data; combinational from address; 0 when not hit.
- rd_hit  out  1  address[15:2]==BASE_ADDR[15:2]; the top-level uses it to mux rdata onto CPU din.
- int_b  out  1  active-low interrupt to the CPU (registered).
- txd  out  1  serial out; idles high.
- rxd  in  1  serial in; asynchronous, double-flopped internally.

Behaviour:

Register map (offset = address[1:0]):
- 0 DATA
  - Write: push wdata[7:0] to TX FIFO.
  - Read: {8'b0, RX head}, non-destructive; 0 if RX empty.
- 1 STATUS (read-only)
  - bit0 RX_AVAIL
  - bit1 TX_FULL
  - bit2 TX_IDLE (TX FIFO empty and shifter idle)
  - bit3 RX_OVR (sticky)
  - bit4 TX_OVR (sticky)
  - bit5 FRAME_ERR (sticky)
  - bits15:8 RX count
- 2 CTRL
  - Write bit0 POP: pop RX head, self-clearing.
  - Write bit4 CLR: clear sticky bits, self-clearing.
  - Write bit3 FLUSH: empty both FIFOs, self-clearing; an in-progress TX frame completes.
  - bit1 RXIE and bit2 TXIE are persistent and readable.
- 3 BAUD: read/write divisor. Values below 3 are forced to 3.

Write commit:
- A write commits on the clk edge where !rnw && rd_hit. Writes are zero-latency and the block has no wait states.

Reset values:
- txd=1, int_b=1, FIFOs empty, sticky bits 0, RXIE=TXIE=0, BAUD=DEF_DIV, both FSMs IDLE.
- Reset mid-frame aborts immediately; txd returns high on the next cycle.

TX FSM (IDLE→START→DATA→STOP→IDLE):
- Leaves IDLE the cycle after the FIFO goes non-empty, popping the head.
- START, each of 8 DATA bits (LSB first) and STOP each last DIV+1 clocks.
- Goes STOP→START directly if the FIFO is non-empty. Back-to-back frames have no idle gap.

RX FSM (IDLE→START→DATA→STOP→IDLE):
- IDLE detects a falling edge on synchronised rxd.
- START waits (DIV+1)/2 clocks and resamples. If high, it is a false start and the FSM returns to IDLE.
- DATA samples every DIV+1 clocks, 8 bits LSB first.
- STOP sample:
  - High: push the byte.
  - Low: set FRAME_ERR and drop the byte.

Boundary conditions:
- TX push when full: dropped; TX_OVR set.
- RX push when full: dropped; RX_OVR set, unless a POP commits the same cycle, in which case both succeed and count is unchanged.
- POP on empty: ignored.
- DATA write in the same cycle the shifter pops the TX FIFO: both occur.
- FLUSH together with POP: FLUSH wins.

Interrupt:
- int_b <= !((RXIE & RX_AVAIL) | (TXIE & TX_IDLE)), one cycle latency.
- int_b is level-sensitive; software clears it by popping RX or disabling the enable.

Optional Feature:
- Macro: OPC5LS_UART_LOOPBACK_EN.
- Defined: CTRL bit5 LOOP becomes read/write (reset 0). When LOOP=1, the RX synchroniser input is txd instead of rxd, and the txd pin is held high.
- Undefined: bit5 reads 0, writes are ignored, and no loopback mux exists.

Decomposition:
- Package opc5ls_uart_pkg:
  - register offsets (DATA/STATUS/CTRL/BAUD)
  - STATUS and CTRL bit indices
  - TX/RX FSM state encodings
  - MIN_DIV=3
- Sub-module opc5ls_uart_fifo:
  - parameterised width/depth
  - push, pop, flush, full, empty, count, head
  - simultaneous push+pop when full allowed
  - instantiated twice (TX and RX).

Test Plan:
- Reset, read STATUS at FE01 → 16'h0004, int_b=1, txd=1, BAUD reads 433.
- BAUD=3, write DATA=16'h00A5 → txd low 4 clks, then bits 1,0,1,0,0,1,0,1 at 4 clks each, stop high 4 clks; TX_IDLE set after stop.
- BAUD=3, drive rxd frame 0x3C, then CTRL=16'h0002 → int_b low 1 cycle after RX_AVAIL; DATA reads 16'h003C on repeated reads; CTRL=16'h0003 pops, and int_b returns high next cycle.
- Send 9 bytes without popping (RX_DEPTH=8) → count=8, RX_OVR set, head is still the first byte; CTRL=16'h0010 clears RX_OVR.
- rxd low pulse of 1 clk with BAUD=7 → false start, no push. Frame with stop bit low → FRAME_ERR=1, count unchanged.
- With OPC5LS_UART_LOOPBACK_EN: CTRL bit5=1, write DATA=16'h0055 → txd pin stays high, and RX receives 0x55 after 10 bit periods.

Source files
------------

// File: rtl/opc5ls_uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : opc5ls_uart_pkg
// Brief    : Shared constants and types for the OPC5LS memory-mapped UART.
//            Register offsets, STATUS/CTRL bit positions, FSM state encoding
//            and the minimum legal baud divisor.
// Revision : 1.0 - initial release
// ============================================================================
package opc5ls_uart_pkg;

    // Register offsets within the 4-word window (address[1:0])
    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_BAUD   = 2'd3;

    // STATUS bit positions
    localparam int ST_RX_AVAIL  = 0;
    localparam int ST_TX_FULL   = 1;
    localparam int ST_TX_IDLE   = 2;
    localparam int ST_RX_OVR    = 3;
    localparam int ST_TX_OVR    = 4;
    localparam int ST_FRAME_ERR = 5;

    // CTRL bit positions
    localparam int CT_POP   = 0;
    localparam int CT_RXIE  = 1;
    localparam int CT_TXIE  = 2;
    localparam int CT_FLUSH = 3;
    localparam int CT_CLR   = 4;
    localparam int CT_LOOP  = 5;

    // Smallest divisor that still leaves room for a mid-bit RX sample
    localparam logic [15:0] MIN_DIV = 16'd3;

    // Shared by the TX and RX serial FSMs
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    function automatic logic [15:0] clamp_div(input logic [15:0] value);
        return (value < MIN_DIV) ? MIN_DIV : value;
    endfunction

endpackage
`default_nettype wire

// File: rtl/opc5ls_uart_fifo.sv
`default_nettype none
// ============================================================================
// Module   : opc5ls_uart_fifo
// Brief    : Synchronous FIFO with flush. Push while full is accepted only
//            when a pop commits in the same cycle; pop on empty is ignored.
//            Flush has priority over push and pop.
// Revision : 1.0 - initial release
// ============================================================================
module opc5ls_uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic [WIDTH-1:0]         data_i,
    output logic [WIDTH-1:0]         head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int            AW         = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             w_do_pop;
    logic             w_do_push;

    assign full_o    = (count_q == FULL_COUNT);
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign head_o    = mem_q[rd_ptr_q];
    assign w_do_pop  = pop_i && !empty_o;
    assign w_do_push = push_i && (!full_o || w_do_pop);

    // Pointer and occupancy bookkeeping; flush discards everything
    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (w_do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (w_do_push && !w_do_pop)      count_q <= count_q + (AW+1)'(1);
            else if (!w_do_push && w_do_pop) count_q <= count_q - (AW+1)'(1);
        end
    end

    // Storage array, written only on an accepted push
    always_ff @(posedge clk) begin
        if (w_do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
    end

endmodule
`default_nettype wire

// File: rtl/opc5ls_uart.sv
`default_nettype none
// ============================================================================
// Module   : opc5ls_uart
// Brief    : Memory-mapped 8N1 UART for the OPC5LS CPU bus with TX/RX FIFOs,
//            programmable baud divisor and an active-low level interrupt.
//            Optional macro OPC5LS_UART_LOOPBACK_EN adds CTRL.LOOP, which
//            routes the TX line into the RX synchroniser and parks txd high.
// Revision : 1.0 - initial release
// ============================================================================
module opc5ls_uart
    import opc5ls_uart_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'hFE00,
    parameter int          TX_DEPTH  = 8,
    parameter int          RX_DEPTH  = 8,
    parameter logic [15:0] DEF_DIV   = 16'd433
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] address,
    input  logic [15:0] wdata,
    input  logic        rnw,
    output logic [15:0] rdata,
    output logic        rd_hit,
    output logic        int_b,
    output logic        txd,
    input  logic        rxd
);
    localparam int TX_CW = $clog2(TX_DEPTH) + 1;
    localparam int RX_CW = $clog2(RX_DEPTH) + 1;

    // Bus decode
    logic w_wr, w_wr_data, w_wr_ctrl, w_flush, w_pop, w_clr;
    assign rd_hit    = (address[15:2] == BASE_ADDR[15:2]);
    assign w_wr      = !rnw && rd_hit;
    assign w_wr_data = w_wr && (address[1:0] == REG_DATA);
    assign w_wr_ctrl = w_wr && (address[1:0] == REG_CTRL);
    assign w_flush   = w_wr_ctrl && wdata[CT_FLUSH];
    assign w_pop     = w_wr_ctrl && wdata[CT_POP] && !w_flush;
    assign w_clr     = w_wr_ctrl && wdata[CT_CLR];

    logic [15:0] div_q;
    logic        rxie_q, txie_q, rx_ovr_q, tx_ovr_q, ferr_q, int_b_q;
    logic        w_loop, w_rx_in, tx_line_q;

    // FIFOs
    logic [7:0]       w_tx_head, w_rx_head;
    logic             w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
    logic [TX_CW-1:0] w_tx_count;
    logic [RX_CW-1:0] w_rx_count;
    logic             w_tx_pop, w_rx_push, w_rx_ferr;
    logic [7:0]       rx_shift_q, rx_shift_d;

    opc5ls_uart_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk(clk), .reset(reset), .push_i(w_wr_data), .pop_i(w_tx_pop),
        .flush_i(w_flush), .data_i(wdata[7:0]), .head_o(w_tx_head),
        .full_o(w_tx_full), .empty_o(w_tx_empty), .count_o(w_tx_count));

    opc5ls_uart_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk(clk), .reset(reset), .push_i(w_rx_push), .pop_i(w_pop),
        .flush_i(w_flush), .data_i(rx_shift_q), .head_o(w_rx_head),
        .full_o(w_rx_full), .empty_o(w_rx_empty), .count_o(w_rx_count));

    // ---------------------------------------------------------------- TX path
    uart_state_e tx_state_q, tx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic        tx_line_d, w_tx_idle, w_tx_tick;

    assign w_tx_tick = (tx_cnt_q >= div_q);
    assign w_tx_idle = (w_tx_count == '0) && (tx_state_q == ST_IDLE);

    // TX state register; reset aborts a frame and returns the line high
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state_q <= ST_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_line_q  <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_line_q  <= tx_line_d;
        end
    end

    // TX next state: each bit lasts DIV+1 clocks, STOP chains into START
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_w_inc(tx_cnt_q);
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        w_tx_pop   = 1'b0;
        unique case (tx_state_q)
            ST_IDLE: begin
                tx_cnt_d = '0;
                if (!w_tx_empty) begin
                    w_tx_pop   = 1'b1;
                    tx_shift_d = w_tx_head;
                    tx_state_d = ST_START;
                end
            end
            ST_START: if (w_tx_tick) begin
                tx_cnt_d   = '0;
                tx_bit_d   = '0;
                tx_state_d = ST_DATA;
            end
            ST_DATA: if (w_tx_tick) begin
                tx_cnt_d   = '0;
                tx_shift_d = {1'b0, tx_shift_q[7:1]};
                if (tx_bit_q == 3'd7) tx_state_d = ST_STOP;
                else                  tx_bit_d   = tx_bit_q + 3'd1;
            end
            ST_STOP: if (w_tx_tick) begin
                tx_cnt_d = '0;
                if (!w_tx_empty) begin
                    w_tx_pop   = 1'b1;
                    tx_shift_d = w_tx_head;
                    tx_state_d = ST_START;
                end else begin
                    tx_state_d = ST_IDLE;
                end
            end
            default: tx_state_d = ST_IDLE;
        endcase
        unique case (tx_state_d)
            ST_START: tx_line_d = 1'b0;
            ST_DATA:  tx_line_d = tx_shift_d[0];
            default:  tx_line_d = 1'b1;
        endcase
    end

    function automatic logic [15:0] tx_w_inc(input logic [15:0] v);
        return v + 16'd1;
    endfunction

    // ---------------------------------------------------------------- RX path
    uart_state_e rx_state_q, rx_state_d;
    logic [15:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic        rx_meta_q, rx_sync_q, rx_prev_q;
    logic [16:0] w_half_m1;

    // Mid-bit offset for the start-bit resample: (DIV+1)/2 clocks
    assign w_half_m1 = (({1'b0, div_q} + 17'd1) >> 1) - 17'd1;

    // Double-flop synchroniser plus one stage of history for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= w_rx_in;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    // RX state register
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state_q <= ST_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
        end
    end

    // RX next state: resample mid start bit, then sample every DIV+1 clocks
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + 16'd1;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        w_rx_push  = 1'b0;
        w_rx_ferr  = 1'b0;
        unique case (rx_state_q)
            ST_IDLE: begin
                rx_cnt_d = '0;
                if (rx_prev_q && !rx_sync_q) rx_state_d = ST_START;
            end
            ST_START: if ({1'b0, rx_cnt_q} >= w_half_m1) begin
                rx_cnt_d   = '0;
                rx_bit_d   = '0;
                rx_state_d = rx_sync_q ? ST_IDLE : ST_DATA;
            end
            ST_DATA: if (rx_cnt_q >= div_q) begin
                rx_cnt_d   = '0;
                rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                if (rx_bit_q == 3'd7) rx_state_d = ST_STOP;
                else                  rx_bit_d   = rx_bit_q + 3'd1;
            end
            ST_STOP: if (rx_cnt_q >= div_q) begin
                rx_cnt_d   = '0;
                rx_state_d = ST_IDLE;
                if (rx_sync_q) w_rx_push = 1'b1;
                else           w_rx_ferr = 1'b1;
            end
            default: rx_state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------ control registers
    // Divisor, enables, sticky error flags; a new event beats a same-cycle CLR
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q    <= clamp_div(DEF_DIV);
            rxie_q   <= 1'b0;
            txie_q   <= 1'b0;
            rx_ovr_q <= 1'b0;
            tx_ovr_q <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            if (w_wr && (address[1:0] == REG_BAUD)) div_q <= clamp_div(wdata);
            if (w_wr_ctrl) begin
                rxie_q <= wdata[CT_RXIE];
                txie_q <= wdata[CT_TXIE];
            end
            if (w_clr) begin
                rx_ovr_q <= 1'b0;
                tx_ovr_q <= 1'b0;
                ferr_q   <= 1'b0;
            end
            if (w_rx_push && w_rx_full && !w_pop)      rx_ovr_q <= 1'b1;
            if (w_wr_data && w_tx_full && !w_tx_pop)   tx_ovr_q <= 1'b1;
            if (w_rx_ferr)                             ferr_q   <= 1'b1;
        end
    end

`ifdef OPC5LS_UART_LOOPBACK_EN
    logic loop_q;

    // Loopback enable, persistent CTRL bit
    always_ff @(posedge clk) begin
        if (reset)          loop_q <= 1'b0;
        else if (w_wr_ctrl) loop_q <= wdata[CT_LOOP];
    end

    assign w_loop  = loop_q;
    assign w_rx_in = loop_q ? tx_line_q : rxd;
    assign txd     = loop_q ? 1'b1 : tx_line_q;
`else
    assign w_loop  = 1'b0;
    assign w_rx_in = rxd;
    assign txd     = tx_line_q;
`endif

    // Level interrupt, registered for one cycle of latency
    always_ff @(posedge clk) begin
        if (reset) int_b_q <= 1'b1;
        else       int_b_q <= !((rxie_q && !w_rx_empty) || (txie_q && w_tx_idle));
    end
    assign int_b = int_b_q;

    // Side-effect-free read mux
    always_comb begin
        rdata = '0;
        if (rd_hit) begin
            unique case (address[1:0])
                REG_DATA:   rdata = {8'h00, w_rx_empty ? 8'h00 : w_rx_head};
                REG_STATUS: rdata = {8'(w_rx_count), 2'b00, ferr_q, tx_ovr_q,
                                     rx_ovr_q, w_tx_idle, w_tx_full, !w_rx_empty};
                REG_CTRL:   rdata = {10'd0, w_loop, 2'b00, txie_q, rxie_q, 1'b0};
                default:    rdata = div_q;
            endcase
        end
    end

endmodule
`default_nettype wire
